// File: rtl/m_iter_mdu.sv
// RV32M/RV64M multiply/divide coprocessor on the PCPI port: single-cycle multiplier,
// radix-2^DIV_BITS restoring divider, fast special cases and a one-entry DIV/REM result cache.
module m_iter_mdu #(
  parameter int XLEN     = 32,
  parameter int DIV_BITS = 1,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_busy,
  output logic            pcpi_ready,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd
);
  localparam int N  = XLEN / DIV_BITS;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  typedef struct packed {
    logic            vld;
    logic            sgn;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
  } cache_t;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            armed_q, busy_q, ready_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] rs1_q, rs2_q, dq_q, dr_q, dd_q, rd_q;
  cache_t          cache_q;

  // Decode and fast-path evaluation straight off the PCPI operands
  logic            is_m, accept, in_sgn, in_rem, ovf, hit, sp;
  logic [2:0]      in_f3;
  logic [XLEN-1:0] mag1, mag2, sp_q, sp_r;

  assign in_f3  = pcpi_insn[14:12];
  assign is_m   = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001);
  assign accept = (state_q == S_IDLE) && armed_q && pcpi_valid && is_m;
  assign in_sgn = ~in_f3[0];
  assign in_rem = in_f3[1];
  assign mag1   = (in_sgn && pcpi_rs1[XLEN-1]) ? -pcpi_rs1 : pcpi_rs1;
  assign mag2   = (in_sgn && pcpi_rs2[XLEN-1]) ? -pcpi_rs2 : pcpi_rs2;
  assign ovf    = in_sgn && (pcpi_rs1 == SMIN) && (pcpi_rs2 == '1);
  assign hit    = CACHE_EN && cache_q.vld && (cache_q.sgn == in_sgn) &&
                  (cache_q.rs1 == pcpi_rs1) && (cache_q.rs2 == pcpi_rs2);

  always_comb begin
    sp   = 1'b1;
    sp_q = '0;
    sp_r = '0;
    if (pcpi_rs2 == '0) begin
      sp_q = '1;
      sp_r = pcpi_rs1;
    end else if (ovf) begin
      sp_q = pcpi_rs1;
    end else if (hit) begin
      sp_q = cache_q.quo;
      sp_r = cache_q.rem;
    end else if (mag1 < mag2) begin
      sp_r = pcpi_rs1;
    end else begin
      sp = 1'b0;
    end
  end

  // Both operands widened to the full product width so one signed multiply covers all variants
  logic                     mul_s1, mul_s2;
  logic signed [2*XLEN+1:0] mul_a, mul_b, mul_p;
  logic [XLEN-1:0]          mul_res;

  assign mul_s1  = (f3_q == 3'd1) || (f3_q == 3'd2);
  assign mul_s2  = (f3_q == 3'd1);
  assign mul_a   = {{(XLEN+2){mul_s1 & rs1_q[XLEN-1]}}, rs1_q};
  assign mul_b   = {{(XLEN+2){mul_s2 & rs2_q[XLEN-1]}}, rs2_q};
  assign mul_p   = mul_a * mul_b;
  assign mul_res = (f3_q[1:0] == 2'd0) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];

  // DIV_BITS restoring steps per cycle; dq holds dividend bits shifting out, quotient bits in
  logic [XLEN-1:0] dq_d, dr_d;
  logic [XLEN:0]   step_t;

  always_comb begin
    dq_d   = dq_q;
    dr_d   = dr_q;
    step_t = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      step_t = {dr_d, dq_d[XLEN-1]};
      dq_d   = {dq_d[XLEN-2:0], 1'b0};
      if (step_t >= {1'b0, dd_q}) begin
        step_t  = step_t - {1'b0, dd_q};
        dq_d[0] = 1'b1;
      end
      dr_d = step_t[XLEN-1:0];
    end
  end

  logic            fix_sgn;
  logic [XLEN-1:0] fix_q, fix_r;

  assign fix_sgn = ~f3_q[0];
  assign fix_q   = (fix_sgn && (rs1_q[XLEN-1] ^ rs2_q[XLEN-1])) ? -dq_q : dq_q;
  assign fix_r   = (fix_sgn && rs1_q[XLEN-1]) ? -dr_q : dr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      f3_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      dq_q    <= '0;
      dr_q    <= '0;
      dd_q    <= '0;
      rd_q    <= '0;
      cache_q <= '0;
    end else begin
      ready_q <= 1'b0;
      rd_q    <= '0;
      case (state_q)
        S_IDLE: begin
          if (!pcpi_valid) armed_q <= 1'b1;
          if (accept) begin
            armed_q <= 1'b0;
            f3_q    <= in_f3;
            rs1_q   <= pcpi_rs1;
            rs2_q   <= pcpi_rs2;
            cnt_q   <= '0;
            dq_q    <= mag1;
            dr_q    <= '0;
            dd_q    <= mag2;
            if (!in_f3[2]) begin
              state_q <= S_MUL;
              busy_q  <= 1'b1;
            end else if (sp) begin
              state_q <= S_DONE;
              ready_q <= 1'b1;
              rd_q    <= in_rem ? sp_r : sp_q;
              if (CACHE_EN)
                cache_q <= '{vld: 1'b1, sgn: in_sgn, rs1: pcpi_rs1, rs2: pcpi_rs2,
                             quo: sp_q, rem: sp_r};
            end else begin
              state_q <= S_DIV;
              busy_q  <= 1'b1;
            end
          end
        end
        S_MUL: begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          rd_q    <= mul_res;
        end
        S_DIV: begin
          dq_q <= dq_d;
          dr_q <= dr_d;
          if (cnt_q == CNT_LAST) begin
            state_q <= S_FIX;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_FIX: begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          rd_q    <= f3_q[1] ? fix_r : fix_q;
          if (CACHE_EN)
            cache_q <= '{vld: 1'b1, sgn: fix_sgn, rs1: rs1_q, rs2: rs2_q,
                         quo: fix_q, rem: fix_r};
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pcpi_busy  = busy_q;
  assign pcpi_ready = ready_q;
  assign pcpi_wr    = ready_q;
  assign pcpi_rd    = rd_q;

  logic unused_ok;
  assign unused_ok = ^{pcpi_insn[24:15], pcpi_insn[11:7], mul_p[2*XLEN+1:2*XLEN]};
endmodule

// File: tb/tb_m_iter_mdu.sv
// Bench for m_iter_mdu: directed cases plus randomized ops against an arithmetic
// reference model, on a 32-bit/radix-2 and a 64-bit/radix-4 instance.
module tb_m_iter_mdu;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        v32, v64;
  logic [31:0] insn32, insn64;
  logic [31:0] a32, b32, rd32;
  logic [63:0] a64, b64, rd64;
  logic        busy32, rdy32, wr32, busy64, rdy64, wr64;

  int n_chk = 0;
  int n_fail = 0;

  // last divide operands seen by each instance (index 0: 32-bit, 1: 64-bit)
  bit          cv[2];
  bit          cs[2];
  logic [63:0] ca[2], cb[2];

  always #5 clk = ~clk;

  m_iter_mdu #(.XLEN(32), .DIV_BITS(1), .CACHE_EN(1'b1)) dut32 (
    .clk(clk), .resetn(resetn), .pcpi_valid(v32), .pcpi_insn(insn32),
    .pcpi_rs1(a32), .pcpi_rs2(b32), .pcpi_busy(busy32), .pcpi_ready(rdy32),
    .pcpi_wr(wr32), .pcpi_rd(rd32));

  m_iter_mdu #(.XLEN(64), .DIV_BITS(2), .CACHE_EN(1'b1)) dut64 (
    .clk(clk), .resetn(resetn), .pcpi_valid(v64), .pcpi_insn(insn64),
    .pcpi_rs1(a64), .pcpi_rs2(b64), .pcpi_busy(busy64), .pcpi_ready(rdy64),
    .pcpi_wr(wr64), .pcpi_rd(rd64));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_insn(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [63:0] wmask(input int w);
    return (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  // two's-complement value of a w-bit pattern
  function automatic logic signed [129:0] sval(input int w, input logic [63:0] x);
    logic signed [129:0] u;
    u = {66'd0, x};
    if (x[w-1]) u = u - (130'sd1 <<< w);
    return u;
  endfunction

  function automatic logic [63:0] ref_res(input int w, input logic [2:0] f3,
                                          input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] m, a, b, res;
    logic signed [129:0] sa, sb, ua, ub, p, q, r;
    m  = wmask(w);
    a  = a_in & m;
    b  = b_in & m;
    ua = {66'd0, a};
    ub = {66'd0, b};
    sa = sval(w, a);
    sb = sval(w, b);
    q  = '0;
    r  = '0;
    p  = '0;
    case (f3)
      3'd0: p = ua * ub;
      3'd1: p = (sa * sb) >>> w;
      3'd2: p = (sa * ub) >>> w;
      3'd3: p = (ua * ub) >>> w;
      3'd4, 3'd6: begin
        if (b == 0) begin q = {66'd0, m}; r = ua; end
        else if (sa == -(130'sd1 <<< (w-1)) && sb == -130'sd1) begin q = ua; r = 0; end
        else begin q = sa / sb; r = sa % sb; end
      end
      default: begin
        if (b == 0) begin q = {66'd0, m}; r = ua; end
        else begin q = ua / ub; r = ua % ub; end
      end
    endcase
    if (!f3[2]) res = p[63:0];
    else if (f3[1]) res = r[63:0];
    else res = q[63:0];
    return res & m;
  endfunction

  function automatic int ref_lat(input int w, input logic [2:0] f3,
                                 input logic [63:0] a_in, input logic [63:0] b_in);
    int k, lat;
    bit sgn;
    logic [63:0] m, a, b;
    logic signed [129:0] sa, sb, ma, mb;
    if (!f3[2]) return 2;
    k   = (w == 64) ? 1 : 0;
    m   = wmask(w);
    a   = a_in & m;
    b   = b_in & m;
    sgn = !f3[0];
    sa  = sval(w, a);
    sb  = sval(w, b);
    ma  = sgn ? ((sa < 0) ? -sa : sa) : {66'd0, a};
    mb  = sgn ? ((sb < 0) ? -sb : sb) : {66'd0, b};
    if (b == 0) lat = 1;
    else if (sgn && sa == -(130'sd1 <<< (w-1)) && sb == -130'sd1) lat = 1;
    else if (cv[k] && ca[k] == a && cb[k] == b && cs[k] == sgn) lat = 1;
    else if (ma < mb) lat = 1;
    else lat = w / ((w == 32) ? 1 : 2) + 2;
    cv[k] = 1'b1; ca[k] = a; cb[k] = b; cs[k] = sgn;
    return lat;
  endfunction

  task automatic sample(input int w, output logic bsy, output logic rdy, output logic wr,
                        output logic [63:0] rd);
    if (w == 32) begin
      bsy = busy32; rdy = rdy32; wr = wr32; rd = {32'd0, rd32};
    end else begin
      bsy = busy64; rdy = rdy64; wr = wr64; rd = rd64;
    end
  endtask

  task automatic run(input int w, input logic [2:0] f3, input logic [63:0] a,
                     input logic [63:0] b, input int hold, input string tag,
                     output logic [63:0] got, output int lat);
    logic [63:0] exp, rd;
    int exp_lat;
    bit done, bad, bad2;
    logic bsy, rdy, wr;
    exp     = ref_res(w, f3, a, b);
    exp_lat = ref_lat(w, f3, a, b);
    @(negedge clk);
    if (w == 32) begin
      v32 = 1'b1; insn32 = mk_insn(f3); a32 = a[31:0]; b32 = b[31:0];
    end else begin
      v64 = 1'b1; insn64 = mk_insn(f3); a64 = a; b64 = b;
    end
    lat = 0; done = 0; bad = 0; got = '0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      sample(w, bsy, rdy, wr, rd);
      if ((bsy && rdy) || (wr !== rdy) || (!rdy && rd != 0)) bad = 1;
      if (rdy) begin done = 1; got = rd; end
    end
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".val"}, got, exp);
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".proto"}, 64'(bad), 64'd0);
    if (hold > 0) begin
      bad2 = 0;
      repeat (hold) begin
        @(negedge clk);
        sample(w, bsy, rdy, wr, rd);
        if (bsy || rdy) bad2 = 1;
      end
      chk({tag, ".rearm"}, 64'(bad2), 64'd0);
    end
    if (w == 32) v32 = 1'b0; else v64 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [63:0] pick(input int w);
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = 64'd0;
      1: v = 64'd1;
      2: v = '1;
      3: v = 64'd1 << (w - 1);
      4: v = 64'($urandom_range(0, 20));
      default: v = {$urandom, $urandom};
    endcase
    return v & wmask(w);
  endfunction

  initial begin
    logic [63:0] got, a, b, pa, pb;
    logic [2:0]  f3;
    int lat;
    bit flag;
    v32 = 0; v64 = 0; insn32 = '0; insn64 = '0;
    a32 = '0; b32 = '0; a64 = '0; b64 = '0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.busy", 64'(busy32), 64'd0);
    chk("rst.ready", 64'(rdy32), 64'd0);
    chk("rst.wr", 64'(wr32), 64'd0);
    chk("rst.rd", 64'(rd32), 64'd0);
    chk("rst64.busy", 64'(busy64), 64'd0);
    chk("rst64.rd", rd64, 64'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    run(32, 3'd1, 64'h8000_0000, 64'h8000_0000, 0, "mulh", got, lat);
    chk("mulh.k", got, 64'h4000_0000);
    chk("mulh.lat_k", 64'(lat), 64'd2);
    run(32, 3'd2, 64'hFFFF_FFFF, 64'd2, 0, "mulhsu", got, lat);
    chk("mulhsu.k", got, 64'hFFFF_FFFF);
    run(32, 3'd0, 64'd7, 64'd6, 0, "mul", got, lat);
    chk("mul.k", got, 64'd42);

    run(32, 3'd4, 64'hFFFF_FFF9, 64'd2, 0, "div", got, lat);
    chk("div.k", got, 64'hFFFF_FFFD);
    chk("div.lat_k", 64'(lat), 64'd34);
    run(32, 3'd6, 64'hFFFF_FFF9, 64'd2, 0, "rem_hit", got, lat);
    chk("rem_hit.k", got, 64'hFFFF_FFFF);
    chk("rem_hit.lat_k", 64'(lat), 64'd1);
    run(32, 3'd7, 64'hFFFF_FFF9, 64'd2, 0, "remu_miss", got, lat);
    chk("remu_miss.lat_k", 64'(lat), 64'd34);

    run(32, 3'd5, 64'd5, 64'd0, 0, "divu_z", got, lat);
    chk("divu_z.k", got, 64'hFFFF_FFFF);
    chk("divu_z.lat_k", 64'(lat), 64'd1);
    run(32, 3'd6, 64'd5, 64'd0, 0, "rem_z", got, lat);
    chk("rem_z.k", got, 64'd5);
    run(32, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 0, "div_ovf", got, lat);
    chk("div_ovf.k", got, 64'h8000_0000);
    run(32, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 0, "rem_ovf", got, lat);
    chk("rem_ovf.k", got, 64'd0);
    run(32, 3'd5, 64'd3, 64'd10, 0, "divu_eo", got, lat);
    chk("divu_eo.k", got, 64'd0);
    chk("divu_eo.lat_k", 64'(lat), 64'd1);
    run(32, 3'd6, 64'hFFFF_FFFD, 64'd10, 0, "rem_eo", got, lat);
    chk("rem_eo.k", got, 64'hFFFF_FFFD);

    // reset in the middle of a long divide
    @(negedge clk);
    v32 = 1'b1; insn32 = mk_insn(3'd5); a32 = 32'd1000; b32 = 32'd3;
    repeat (10) @(posedge clk);
    #2;
    chk("mid.busy_pre", 64'(busy32), 64'd1);
    resetn = 1'b0;
    v32 = 1'b0;
    #1;
    chk("mid.busy", 64'(busy32), 64'd0);
    chk("mid.ready", 64'(rdy32), 64'd0);
    chk("mid.wr", 64'(wr32), 64'd0);
    chk("mid.rd", 64'(rd32), 64'd0);
    flag = 0;
    repeat (3) begin
      @(negedge clk);
      if (rdy32 || busy32) flag = 1;
    end
    chk("mid.quiet", 64'(flag), 64'd0);
    resetn = 1'b1;
    cv[0] = 1'b0; cv[1] = 1'b0;
    repeat (2) @(negedge clk);
    run(32, 3'd5, 64'd100, 64'd7, 3, "divu_rst", got, lat);
    chk("divu_rst.k", got, 64'd14);
    chk("divu_rst.lat_k", 64'(lat), 64'd34);

    // non-M instruction is ignored
    @(negedge clk);
    v32 = 1'b1; insn32 = {7'b0000000, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011};
    a32 = 32'd9; b32 = 32'd4;
    flag = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy32 || rdy32 || rd32 != 0) flag = 1;
    end
    chk("nonm.quiet", 64'(flag), 64'd0);
    v32 = 1'b0;
    repeat (2) @(negedge clk);

    run(64, 3'd5, 64'h8000_0000_0000_0000, 64'd3, 0, "divu64", got, lat);
    chk("divu64.k", got, 64'h2AAA_AAAA_AAAA_AAAA);
    chk("divu64.lat_k", 64'(lat), 64'd34);

    pa = '0; pb = '0;
    for (int i = 0; i < 150; i++) begin
      f3 = 3'($urandom_range(0, 7));
      if (i > 0 && $urandom_range(0, 3) == 0) begin a = pa; b = pb; end
      else begin a = pick(32); b = pick(32); end
      run(32, f3, a, b, 0, "rnd32", got, lat);
      pa = a; pb = b;
    end
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      if (i > 0 && $urandom_range(0, 3) == 0) begin a = pa; b = pb; end
      else begin a = pick(64); b = pick(64); end
      run(64, f3, a, b, 0, "rnd64", got, lat);
      pa = a; pb = b;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
